// File: rtl/led_snake_decoder_pkg.sv
// Shared constants, FSM state type and rotation helper for the LED snake
// receive-side decoder.
package led_snake_pkg;

    localparam int LED_W   = 16;
    localparam int MAX_RUN = 8;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // One-position left rotation, matching the generator's advance direction.
    function automatic logic [LED_W-1:0] rotl1(input logic [LED_W-1:0] v);
        return {v[LED_W-2:0], v[LED_W-1]};
    endfunction

endpackage

// File: rtl/led_snake_decoder_if.sv
// LED sample bus plus decoder status outputs; master drives samples,
// slave (the decoder) returns lock state and statistics.
interface led_snake_decoder_if #(
    parameter int ERR_CNT_W  = 8,
    parameter int STEP_CNT_W = 16
);

    logic                  i_led_valid;
    logic [15:0]           i_led;
    logic                  o_locked;
    logic [2:0]            o_length_code;
    logic [3:0]            o_head;
    logic                  o_err;
    logic [ERR_CNT_W-1:0]  o_err_count;
    logic [STEP_CNT_W-1:0] o_step_count;

    modport master (
        output i_led_valid, i_led,
        input  o_locked, o_length_code, o_head, o_err, o_err_count, o_step_count
    );

    modport slave (
        input  i_led_valid, i_led,
        output o_locked, o_length_code, o_head, o_err, o_err_count, o_step_count
    );

endinterface

// File: rtl/led_snake_decoder_run_analyzer.sv
// Combinational shape check of one LED sample: a single circular run of
// 1..MAX_RUN ones, reporting its length-1 and the index of its leading bit.
module led_run_analyzer
    import led_snake_pkg::*;
(
    input  logic [LED_W-1:0] i_led,
    output logic             o_well_formed,
    output logic [2:0]       o_run_len_m1,
    output logic [3:0]       o_head
);

    logic [4:0] w_pop;
    logic [4:0] w_rises;

    // A single run has exactly one 0->1 edge and one 1->0 edge going upward
    // around the ring; the 1->0 edge marks the head.
    always_comb begin
        w_pop   = '0;
        w_rises = '0;
        o_head  = '0;
        for (int i = 0; i < LED_W; i++) begin
            w_pop = w_pop + {4'd0, i_led[i]};
            if (!i_led[i] && i_led[(i + 1) % LED_W])
                w_rises = w_rises + 5'd1;
            if (i_led[i] && !i_led[(i + 1) % LED_W])
                o_head = i[3:0];
        end
    end

    assign o_run_len_m1  = 3'(w_pop - 5'd1);
    assign o_well_formed = (w_pop >= 5'd1) && (w_pop <= 5'(MAX_RUN)) && (w_rises == 5'd1);

endmodule

// File: rtl/led_snake_decoder.sv
// Locks onto the rotating snake pattern, flags illegal transitions while
// locked and keeps saturating error / wrapping step statistics.
module led_snake_decoder
    import led_snake_pkg::*;
#(
    parameter int ERR_CNT_W  = 8,
    parameter int STEP_CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    led_snake_decoder_if.slave bus
);

    state_t                r_state;
    state_t                w_nextState;
    logic [LED_W-1:0]      r_pattern;
    logic [2:0]            r_lengthCode;
    logic [3:0]            r_head;
    logic                  r_err;
    logic [ERR_CNT_W-1:0]  r_errCount;
    logic [STEP_CNT_W-1:0] r_stepCount;

    logic                  w_wellFormed;
    logic [2:0]            w_runLenM1;
    logic [3:0]            w_head;
    logic                  w_isHold;
    logic                  w_isStep;
    logic                  w_loadP;
    logic                  w_stepInc;
    logic                  w_violation;

    led_run_analyzer u_analyzer (
        .i_led         (bus.i_led),
        .o_well_formed (w_wellFormed),
        .o_run_len_m1  (w_runLenM1),
        .o_head        (w_head)
    );

    assign w_isHold = (bus.i_led == r_pattern);
    assign w_isStep = (bus.i_led == rotl1(r_pattern));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= SEARCH;
        else
            r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        if (bus.i_led_valid) begin
            case (r_state)
                SEARCH: begin
                    if (w_wellFormed)
                        w_nextState = CONFIRM;
                end
                CONFIRM: begin
                    if (w_isHold)
                        w_nextState = CONFIRM;
                    else if (w_isStep)
                        w_nextState = LOCKED;
                    else if (!w_wellFormed)
                        w_nextState = SEARCH;
                end
                LOCKED: begin
                    if (!(w_isHold || w_isStep))
                        w_nextState = w_wellFormed ? CONFIRM : SEARCH;
                end
                default: w_nextState = SEARCH;
            endcase
        end
    end

    // Pattern-store / counter controls derived from the current state and sample.
    always_comb begin
        w_loadP     = 1'b0;
        w_stepInc   = 1'b0;
        w_violation = 1'b0;
        if (bus.i_led_valid) begin
            case (r_state)
                SEARCH: w_loadP = w_wellFormed;
                CONFIRM: begin
                    if (w_isStep) begin
                        w_loadP   = 1'b1;
                        w_stepInc = 1'b1;
                    end else if (!w_isHold) begin
                        w_loadP = w_wellFormed;
                    end
                end
                LOCKED: begin
                    if (w_isStep) begin
                        w_loadP   = 1'b1;
                        w_stepInc = 1'b1;
                    end else if (!w_isHold) begin
                        w_violation = 1'b1;
                        w_loadP     = w_wellFormed;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pattern    <= '0;
            r_lengthCode <= '0;
            r_head       <= '0;
            r_err        <= 1'b0;
            r_errCount   <= '0;
            r_stepCount  <= '0;
        end else begin
            r_err <= w_violation;
            if (w_loadP) begin
                r_pattern    <= bus.i_led;
                r_lengthCode <= w_runLenM1;
                r_head       <= w_head;
            end
            if (w_violation && (r_errCount != '1))
                r_errCount <= r_errCount + 1'b1;
            if (w_stepInc)
                r_stepCount <= r_stepCount + 1'b1;
        end
    end

    assign bus.o_locked      = (r_state == LOCKED);
    assign bus.o_length_code = r_lengthCode;
    assign bus.o_head        = r_head;
    assign bus.o_err         = r_err;
    assign bus.o_err_count   = r_errCount;
    assign bus.o_step_count  = r_stepCount;

endmodule

// File: doc/led_snake_decoder.md
Name: led_snake_decoder

Overview:
Receive-side checker for the rotating LED "snake" pattern driven onto the 16-bit LED bus by the snake generator. The generator produces a circular run of n ones (n = 1..8) that rotates left by one position per advance. This block samples the bus on a strobe, recovers the run length and head position, and locks onto the rotation. It flags any sample that is neither a hold nor a legal one-step rotation, and keeps error and step statistics for the board-level self-test.

Parameters:
LED_W, 16, LED bus width; fixed at 16, other values unsupported
MAX_RUN, 8, largest legal run length
ERR_CNT_W, 8, width of the saturating error counter
STEP_CNT_W, 16, width of the wrapping step counter

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
led_valid  input  1  sample strobe; led is evaluated only on edges where this is 1
led  input  16  observed LED pattern
locked  output  1  1 while tracking a legal rotation
length_code  output  3  run length minus 1 (same encoding as generator switch)
head  output  4  index i of run's leading bit: led[i]=1 and led[(i+1) mod 16]=0
err  output  1  one-cycle pulse on a protocol violation while locked
err_count  output  ERR_CNT_W  violations seen; saturates at all-ones
step_count  output  STEP_CNT_W  accepted rotation steps while locked; wraps

Behaviour:
- Reset (async, takes effect immediately): state=SEARCH, locked=0, length_code=0, head=0, err=0, err_count=0, step_count=0, stored pattern P=0.
- All outputs are registered. They update on the clk edge that samples led_valid=1 and are visible in the following cycle. With led_valid=0 all state and outputs hold, and err=0.
- Well-formed sample S:
  - popcount(S) is in 1..MAX_RUN.
  - Exactly one circular rising edge exists: a count of 1 for i where S[i]=0 and S[(i+1) mod 16]=1.
  - 0x0000, 0xFFFF and any split run are malformed.
- Relations to P: HOLD if S==P. STEP if S==rotl(P,1), i.e. {P[14:0],P[15]}.
- States:
  - SEARCH: well-formed S -> CONFIRM, P<=S. Malformed S -> stay in SEARCH.
  - CONFIRM:
    - HOLD -> stay.
    - STEP -> LOCKED, P<=S, step_count+1.
    - Other well-formed S -> stay in CONFIRM, P<=S.
    - Malformed S -> SEARCH.
  - LOCKED:
    - HOLD -> stay, no count change.
    - STEP -> P<=S, step_count+1.
    - Anything else -> err=1 for one cycle, err_count+1 (saturating). Then CONFIRM with P<=S if S is well-formed, else SEARCH.
- locked = (state==LOCKED).
- length_code and head are recomputed from P whenever P is loaded; otherwise they hold their last value, including after lock loss.
- No err is raised in SEARCH or CONFIRM.
- A length change (generator switch change plus generator reset) is a violation while LOCKED, then relocks via CONFIRM.
- Run-length change with a legal shape is never accepted as a STEP, because popcount is preserved by rotation.
- Wrap-around: a run straddling bit 15/bit 0 is legal, e.g. 0xC001 has n=3, head=0.
- step_count wraps from all-ones to 0. err_count holds at all-ones.

Decomposition:
- Package led_snake_pkg:
  - LED_W, MAX_RUN
  - state enum {SEARCH, CONFIRM, LOCKED}
  - rotl1 function
- Sub-module led_run_analyzer (combinational): input led[15:0]; outputs well_formed, run_len_m1[2:0], head[3:0].
- The top level holds the FSM, P, and the counters.

Test Plan:
- Reset, then valid 0x0007, then valid 0x000E -> after 2nd edge: locked=1, length_code=2, head=3, step_count=1, err=0.
- Locked on 0xC001 (length_code=2, head=0), then valid 0x8003 -> head=1, step_count+1, locked stays 1; wrap across bit 15 accepted.
- Locked on 0x00F0: three valid samples of 0x00F0, plus led_valid=0 cycles carrying garbage 0x1234 -> no err, step_count unchanged, length_code=3, head=7.
- Locked on 0x0038, then valid 0x0031 -> err=1 for exactly one cycle, err_count=1, locked=0, state SEARCH. Then 0x0007, 0x000E -> relocked, length_code=2.
- Valid 0x01FF (popcount 9) and 0x0505 (split run) repeatedly -> never locks, err never pulses. Separately, 300 forced violations alternating 0x0003/0x0006/0x0300 patterns -> err_count saturates at 255.
- Locked with step_count=5, rst asserted mid-cycle -> locked=0, step_count=0, err_count=0 before the next clk edge. After release, 0x00FF then 0x01FE -> locked, length_code=7, head=8.
